// File: rtl/icache_fetch.sv
// Direct-mapped instruction cache with a sequential line-refill controller.
// Hits answer combinationally in the PC cycle; misses stall while a line is refilled.
module icache_fetch #(
    parameter int LINES   = 8,
    parameter int WORDS   = 4,
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        pc_valid,
    input  logic        flush,
    output logic [31:0] instruction,
    output logic        stall,
    output logic [31:0] mem_address,
    output logic        mem_read,
    input  logic [31:0] mem_instruction,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);

    localparam int INDEX_BITS = $clog2(LINES);
    localparam int OFF_BITS   = $clog2(WORDS);
    localparam int TAG_BITS   = 30 - INDEX_BITS - OFF_BITS;
    localparam int WAIT_BITS  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    localparam logic [WAIT_BITS-1:0] WAIT_LAST = WAIT_BITS'(MEM_LAT - 1);
    localparam logic [OFF_BITS-1:0]  WORD_LAST = OFF_BITS'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        FILL_DONE
    } state_t;

    state_t state, state_next;

    logic [LINES-1:0]    valid;
    logic [TAG_BITS-1:0] tag_arr  [LINES];
    logic [31:0]         data_arr [LINES][WORDS];

    logic [TAG_BITS-1:0]   lat_tag;
    logic [INDEX_BITS-1:0] lat_index;
    logic [OFF_BITS-1:0]   word_cnt;
    logic [OFF_BITS-1:0]   word_next;
    logic [WAIT_BITS-1:0]  wait_cnt;

    logic [OFF_BITS-1:0]   pc_off;
    logic [INDEX_BITS-1:0] pc_idx;
    logic [TAG_BITS-1:0]   pc_tag;
    logic                  unused_pc_bits;

    logic hit;
    logic miss;
    logic word_done;
    logic last_word;

    assign pc_off         = pc[OFF_BITS+1:2];
    assign pc_idx         = pc[INDEX_BITS+OFF_BITS+1:OFF_BITS+2];
    assign pc_tag         = pc[31:INDEX_BITS+OFF_BITS+2];
    assign unused_pc_bits = ^pc[1:0];

    assign hit       = (state == IDLE) && pc_valid && valid[pc_idx] && (tag_arr[pc_idx] == pc_tag);
    assign miss      = (state == IDLE) && pc_valid && !hit;
    assign word_done = (state == REFILL) && (wait_cnt == WAIT_LAST);
    assign last_word = word_done && (word_cnt == WORD_LAST);
    assign word_next = word_cnt + OFF_BITS'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        stall       = 1'b0;
        instruction = '0;
        case (state)
            IDLE: begin
                if (hit) begin
                    instruction = data_arr[pc_idx][pc_off];
                end
                if (miss) begin
                    stall      = 1'b1;
                    state_next = REFILL;
                end
            end
            REFILL: begin
                stall = 1'b1;
                if (last_word) begin
                    state_next = FILL_DONE;
                end
            end
            FILL_DONE: begin
                stall      = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // flush overrides any transition, including a miss seen this cycle
        if (flush) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid       <= '0;
            hit_count   <= '0;
            miss_count  <= '0;
            mem_read    <= 1'b0;
            mem_address <= '0;
            lat_tag     <= '0;
            lat_index   <= '0;
            word_cnt    <= '0;
            wait_cnt    <= '0;
        end else begin
            if (hit && hit_count != 16'hFFFF) begin
                hit_count <= hit_count + 16'd1;
            end
            if (flush) begin
                valid    <= '0;
                mem_read <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (miss) begin
                            lat_tag       <= pc_tag;
                            lat_index     <= pc_idx;
                            valid[pc_idx] <= 1'b0;
                            word_cnt      <= '0;
                            wait_cnt      <= '0;
                            mem_read      <= 1'b1;
                            mem_address   <= {pc_tag, pc_idx, {OFF_BITS{1'b0}}, 2'b00};
                            if (miss_count != 16'hFFFF) begin
                                miss_count <= miss_count + 16'd1;
                            end
                        end
                    end
                    REFILL: begin
                        if (word_done) begin
                            wait_cnt <= '0;
                            word_cnt <= word_next;
                            if (last_word) begin
                                mem_read <= 1'b0;
                            end else begin
                                mem_address <= {lat_tag, lat_index, word_next, 2'b00};
                            end
                        end else begin
                            wait_cnt <= wait_cnt + WAIT_BITS'(1);
                        end
                    end
                    FILL_DONE: begin
                        valid[lat_index] <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Tag and data storage carry no reset; valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (word_done) begin
            data_arr[lat_index][word_cnt] <= mem_instruction;
        end
        if (state == FILL_DONE) begin
            tag_arr[lat_index] <= lat_tag;
        end
    end

endmodule

// File: tb/tb_icache_fetch.sv
// Bench for icache_fetch: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a line-level reference model.
module tb_icache_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc = '0;
    logic        pc_valid = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] instruction;
    logic        stall;
    logic [31:0] mem_address;
    logic        mem_read;
    logic [31:0] mem_instruction;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    logic [31:0] pc3 = '0;
    logic        pc_valid3 = 1'b0;
    logic [31:0] instruction3;
    logic        stall3;
    logic [31:0] mem_address3;
    logic        mem_read3;
    logic [31:0] mem_instruction3;
    logic [15:0] hit_count3;
    logic [15:0] miss_count3;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // memory word k holds 32'h1000_0000 + k
    assign mem_instruction  = 32'h1000_0000 + {20'b0, mem_address[13:2]};
    assign mem_instruction3 = 32'h1000_0000 + {20'b0, mem_address3[13:2]};

    icache_fetch dut (
        .clk(clk), .reset(reset), .pc(pc), .pc_valid(pc_valid), .flush(flush),
        .instruction(instruction), .stall(stall), .mem_address(mem_address),
        .mem_read(mem_read), .mem_instruction(mem_instruction),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    icache_fetch #(.LINES(8), .WORDS(4), .MEM_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .pc(pc3), .pc_valid(pc_valid3), .flush(1'b0),
        .instruction(instruction3), .stall(stall3), .mem_address(mem_address3),
        .mem_read(mem_read3), .mem_instruction(mem_instruction3),
        .hit_count(hit_count3), .miss_count(miss_count3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] pc;
        logic        v;
        logic        stall;
        logic [31:0] instr;
        logic        mr;
        logic [31:0] addr;
        int          hits;
        int          misses;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [31:0] p, logic v, logic s, logic [31:0] ins,
                                logic mr, logic [31:0] a, int h, int m);
        vec_t t;
        t.pc = p; t.v = v; t.stall = s; t.instr = ins; t.mr = mr; t.addr = a;
        t.hits = h; t.misses = m;
        return t;
    endfunction

    // reference model state: per-line tag/valid, refill phase counter
    logic [24:0] m_tag[8];
    bit          m_valid[8];
    int          m_phase;
    logic [31:0] m_base;
    int          m_hits, m_misses;

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_valid[i] = 0;
        m_phase = 0; m_hits = 0; m_misses = 0;
    endtask

    initial begin
        int stall_cycles;
        logic [31:0] addrs[$];
        logic [31:0] got;

        tick(); tick();
        reset = 1'b0;
        @(negedge clk);
        chk("reset_stall", {31'b0, stall}, 32'd0);
        chk("reset_mem_read", {31'b0, mem_read}, 32'd0);
        chk("reset_mem_address", mem_address, 32'd0);
        chk("reset_instruction", instruction, 32'd0);
        chk("reset_hit_count", {16'b0, hit_count}, 32'd0);
        chk("reset_miss_count", {16'b0, miss_count}, 32'd0);
        tick();

        // cold miss on line 0, hits on its words, conflict miss via 0x80
        tbl.push_back(mk(32'h00, 1, 1, 32'h0,        0, 32'h00, 0, 0));
        tbl.push_back(mk(32'h00, 1, 1, 32'h0,        1, 32'h00, 0, 1));
        tbl.push_back(mk(32'h00, 1, 1, 32'h0,        1, 32'h04, 0, 1));
        tbl.push_back(mk(32'h00, 1, 1, 32'h0,        1, 32'h08, 0, 1));
        tbl.push_back(mk(32'h00, 1, 1, 32'h0,        1, 32'h0C, 0, 1));
        tbl.push_back(mk(32'h00, 1, 1, 32'h0,        0, 32'h00, 0, 1));
        tbl.push_back(mk(32'h00, 1, 0, 32'h10000000, 0, 32'h00, 0, 1));
        tbl.push_back(mk(32'h04, 1, 0, 32'h10000001, 0, 32'h00, 1, 1));
        tbl.push_back(mk(32'h08, 1, 0, 32'h10000002, 0, 32'h00, 2, 1));
        tbl.push_back(mk(32'h0C, 1, 0, 32'h10000003, 0, 32'h00, 3, 1));
        tbl.push_back(mk(32'h00, 0, 0, 32'h0,        0, 32'h00, 4, 1));
        tbl.push_back(mk(32'h80, 1, 1, 32'h0,        0, 32'h00, 4, 1));
        tbl.push_back(mk(32'h80, 1, 1, 32'h0,        1, 32'h80, 4, 2));
        tbl.push_back(mk(32'h44, 1, 1, 32'h0,        1, 32'h84, 4, 2));
        tbl.push_back(mk(32'h44, 0, 1, 32'h0,        1, 32'h88, 4, 2));
        tbl.push_back(mk(32'h80, 1, 1, 32'h0,        1, 32'h8C, 4, 2));
        tbl.push_back(mk(32'h80, 1, 1, 32'h0,        0, 32'h00, 4, 2));
        tbl.push_back(mk(32'h80, 1, 0, 32'h10000020, 0, 32'h00, 4, 2));
        tbl.push_back(mk(32'h00, 1, 1, 32'h0,        0, 32'h00, 5, 2));
        tbl.push_back(mk(32'h00, 1, 1, 32'h0,        1, 32'h00, 5, 3));

        foreach (tbl[i]) begin
            pc = tbl[i].pc; pc_valid = tbl[i].v;
            @(negedge clk);
            chk($sformatf("vec%0d_stall", i), {31'b0, stall}, {31'b0, tbl[i].stall});
            chk($sformatf("vec%0d_instr", i), instruction, tbl[i].instr);
            chk($sformatf("vec%0d_mem_read", i), {31'b0, mem_read}, {31'b0, tbl[i].mr});
            if (tbl[i].mr) chk($sformatf("vec%0d_mem_address", i), mem_address, tbl[i].addr);
            chk($sformatf("vec%0d_hits", i), {16'b0, hit_count}, 32'(tbl[i].hits));
            chk($sformatf("vec%0d_misses", i), {16'b0, miss_count}, 32'(tbl[i].misses));
            tick();
        end

        // reset while refilling word 1
        @(negedge clk);
        chk("rst_mid_addr_word1", mem_address, 32'h04);
        reset = 1'b1;
        tick();
        reset = 1'b0; pc_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_hits", {16'b0, hit_count}, 32'd0);
        chk("rst_mid_misses", {16'b0, miss_count}, 32'd0);
        chk("rst_mid_mem_read", {31'b0, mem_read}, 32'd0);
        chk("rst_mid_stall", {31'b0, stall}, 32'd0);
        tick();
        pc = 32'h0; pc_valid = 1'b1;
        @(negedge clk);
        chk("rst_mid_line_invalid", {31'b0, stall}, 32'd1);
        tick();

        // flush while refilling word 2
        @(negedge clk); chk("flush_word0", mem_address, 32'h00); tick();
        @(negedge clk); chk("flush_word1", mem_address, 32'h04); tick();
        flush = 1'b1; pc_valid = 1'b0;
        @(negedge clk); chk("flush_word2", mem_address, 32'h08); tick();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_mem_read_off", {31'b0, mem_read}, 32'd0);
        chk("flush_idle_stall", {31'b0, stall}, 32'd0);
        tick();
        pc_valid = 1'b1;
        stall_cycles = 0;
        got = '0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (stall_cycles == 1) chk("flush_refill_from_word0", mem_address, 32'h00);
            if (!stall) begin
                got = instruction;
                break;
            end
            stall_cycles++;
            tick();
        end
        chk("flush_refill_stall_cycles", 32'(stall_cycles), 32'd6);
        chk("flush_refill_instr", got, 32'h10000000);
        chk("flush_miss_count", {16'b0, miss_count}, 32'd2);
        tick();
        pc_valid = 1'b0;

        // MEM_LAT=3 instance
        reset = 1'b1; tick(); reset = 1'b0;
        pc3 = 32'h40; pc_valid3 = 1'b1;
        stall_cycles = 0;
        got = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (mem_read3) addrs.push_back(mem_address3);
            if (!stall3) begin
                got = instruction3;
                break;
            end
            stall_cycles++;
            tick();
        end
        chk("lat3_stall_cycles", 32'(stall_cycles), 32'd14);
        chk("lat3_addr_count", 32'(addrs.size()), 32'd12);
        foreach (addrs[i]) chk($sformatf("lat3_addr%0d", i), addrs[i], 32'h40 + 32'(4 * (i / 3)));
        chk("lat3_instr", got, 32'h10000010);
        tick();
        pc_valid3 = 1'b0;

        // randomized traffic against the line-level model
        reset = 1'b1; tick(); reset = 1'b0;
        model_clear();
        for (int n = 0; n < 3000; n++) begin
            logic r, v, fl, hit, e_stall, e_mr;
            logic [31:0] p, e_instr, e_addr;
            int idx;
            logic [24:0] tg;
            r  = ($urandom_range(0, 199) == 0);
            v  = ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 59) == 0);
            p  = 32'($urandom_range(0, 255)) << 2;
            pc = p; pc_valid = v; flush = fl; reset = r;
            idx = int'(p[6:4]);
            tg  = p[31:7];
            hit = 1'b0; e_addr = '0;
            if (m_phase == 0) begin
                hit = v && m_valid[idx] && (m_tag[idx] == tg);
                e_stall = v && !hit;
                e_instr = hit ? 32'h10000000 + {20'b0, p[13:2]} : 32'h0;
                e_mr = 1'b0;
            end else begin
                e_stall = 1'b1;
                e_instr = 32'h0;
                e_mr = (m_phase <= 4);
                e_addr = m_base + 32'(4 * (m_phase - 1));
            end
            @(negedge clk);
            chk("rnd_stall", {31'b0, stall}, {31'b0, e_stall});
            chk("rnd_instr", instruction, e_instr);
            chk("rnd_mem_read", {31'b0, mem_read}, {31'b0, e_mr});
            if (e_mr) chk("rnd_mem_address", mem_address, e_addr);
            chk("rnd_hits", {16'b0, hit_count}, 32'(m_hits));
            chk("rnd_misses", {16'b0, miss_count}, 32'(m_misses));
            if (r) begin
                model_clear();
            end else begin
                if (hit && m_hits < 65535) m_hits++;
                if (fl) begin
                    for (int i = 0; i < 8; i++) m_valid[i] = 0;
                    m_phase = 0;
                end else if (m_phase == 0 && v && !hit) begin
                    m_valid[idx] = 0;
                    m_tag[idx] = tg;
                    m_base = {p[31:4], 4'b0};
                    m_phase = 1;
                    if (m_misses < 65535) m_misses++;
                end else if (m_phase == 5) begin
                    m_valid[int'(m_base[6:4])] = 1;
                    m_phase = 0;
                end else if (m_phase > 0) begin
                    m_phase++;
                end
            end
            tick();
        end
        reset = 1'b0; flush = 1'b0; pc_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
